gf_2ton_koa_merger_scheduler: RTL and testbench

- Round-robin scheduler that shares one fixed-latency GF(2^N) Karatsuba multiply/merge line between N_REQ requesters (e.g. parallel GHASH lanes).
- Arbitrates operand requests, registers the winning operand bus into the datapath, and tracks an ID per issue through a tag pipeline matched to the datapath latency.
- Steers each result back to the requester that issued it and enforces a per-requester outstanding-operation limit.

---
 rtl/gf_2ton_koa_merger_scheduler_pkg.sv | 25 ++
 rtl/gf_2ton_koa_merger_scheduler_rr_arbiter.sv | 38 +++
 rtl/gf_2ton_koa_merger_scheduler.sv | 157 +++++++++++++++
 tb/tb_gf_2ton_koa_merger_scheduler.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gf_2ton_koa_merger_scheduler_pkg.sv
// Shared definitions for the GF(2^N) Karatsuba merger line and its scheduler.
//
// Contents:
//   NB_DATA            - field element width of the merger line
//   NB_OPER_DEFAULT    - operand bus width (3*NB_DATA: a, b and the middle term)
//   NB_RESULT_DEFAULT  - merged result width (2*NB_DATA+1)
//   clog2()            - ceiling log2, usable in constant expressions

package gf_2ton_koa_merger_scheduler_pkg;

    localparam int unsigned NB_DATA           = 128;
    localparam int unsigned NB_OPER_DEFAULT   = 3 * NB_DATA;
    localparam int unsigned NB_RESULT_DEFAULT = 2 * NB_DATA + 1;

    // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/gf_2ton_koa_merger_scheduler_rr_arbiter.sv
// Combinational one-hot round-robin picker.
//
// Ports:
//   eligible - per-requester eligibility vector
//   pointer  - index at which the search starts (wraps modulo N_REQ)
//   grant    - one-hot grant, all zero when nothing is eligible
//   index    - binary index of the granted requester (0 when no grant)
//   any      - high when a grant is made

module gf_2ton_koa_merger_scheduler_rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned NB_ID = 2
) (
    input  logic [N_REQ-1:0] eligible,
    input  logic [NB_ID-1:0] pointer,
    output logic [N_REQ-1:0] grant,
    output logic [NB_ID-1:0] index,
    output logic             any
);

    logic [NB_ID-1:0] cand;

    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        cand  = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            cand = NB_ID'((int'(pointer) + i) % int'(N_REQ));
            if (!any && eligible[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                index       = cand;
            end
        end
    end

endmodule

// File: rtl/gf_2ton_koa_merger_scheduler.sv
// Round-robin scheduler sharing one fixed-latency GF(2^N) Karatsuba multiply/merge
// line between N_REQ requesters.
//
// Ports:
//   i_clock, i_reset_n       - clock and synchronous active-low reset
//   i_enable                 - low blocks new grants; in-flight work still drains
//   i_req_valid/o_req_ready  - per-requester handshake (o_req_ready one-hot, comb)
//   i_req_data_bus           - requester k operands at [k*NB_OPER +: NB_OPER]
//   o_dp_valid/o_dp_data     - registered issue to the datapath
//   i_dp_data                - datapath result, valid DP_LATENCY cycles after issue
//   o_rsp_valid/o_rsp_id     - one-hot result strobe and owning requester index
//   o_rsp_data               - result forwarded straight from i_dp_data
//   o_idle                   - nothing issued or in flight

module gf_2ton_koa_merger_scheduler
    import gf_2ton_koa_merger_scheduler_pkg::*;
#(
    parameter int unsigned N_REQ           = 4,
    parameter int unsigned NB_OPER         = NB_OPER_DEFAULT,
    parameter int unsigned NB_RESULT       = NB_RESULT_DEFAULT,
    parameter int unsigned DP_LATENCY      = 2,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned NB_ID           = 2
) (
    input  logic                     i_clock,
    input  logic                     i_reset_n,
    input  logic                     i_enable,
    input  logic [N_REQ-1:0]         i_req_valid,
    output logic [N_REQ-1:0]         o_req_ready,
    input  logic [N_REQ*NB_OPER-1:0] i_req_data_bus,
    output logic [NB_OPER-1:0]       o_dp_data,
    output logic                     o_dp_valid,
    input  logic [NB_RESULT-1:0]     i_dp_data,
    output logic [N_REQ-1:0]         o_rsp_valid,
    output logic [NB_RESULT-1:0]     o_rsp_data,
    output logic [NB_ID-1:0]         o_rsp_id,
    output logic                     o_idle
);

    localparam int unsigned NB_CNT   = clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned NB_STAGE = DP_LATENCY + 1;

    // Registered state
    logic [NB_ID-1:0]   ptr_q;
    logic [NB_CNT-1:0]  cnt_q [N_REQ];
    logic [NB_STAGE-1:0] tag_valid_q;
    logic [NB_ID-1:0]   tag_id_q [NB_STAGE];
    logic               dp_valid_q;
    logic [NB_OPER-1:0] dp_data_q;

    // Next-state / combinational
    logic [NB_ID-1:0]   ptr_d;
    logic [NB_CNT-1:0]  cnt_d [N_REQ];
    logic [N_REQ-1:0]   eligible;
    logic [N_REQ-1:0]   grant;
    logic [NB_ID-1:0]   grant_idx;
    logic               grant_any;
    logic [N_REQ-1:0]   rsp_hit;
    logic               out_valid;
    logic [NB_ID-1:0]   out_id;
    logic [NB_OPER-1:0] sel_oper;

    // The last tag stage lines up with the cycle the datapath result is valid.
    assign out_valid = tag_valid_q[DP_LATENCY] & i_reset_n;
    assign out_id    = tag_id_q[DP_LATENCY];

    always_comb begin
        rsp_hit = '0;
        if (out_valid) begin
            rsp_hit[out_id] = 1'b1;
        end
    end

    // A response retiring this cycle frees a slot, so a requester sitting at the
    // limit can be granted in the same cycle; the counter then stays unchanged.
    always_comb begin
        eligible = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            eligible[k] = i_req_valid[k] & i_enable & i_reset_n &
                          ((cnt_q[k] < NB_CNT'(MAX_OUTSTANDING)) | rsp_hit[k]);
        end
    end

    gf_2ton_koa_merger_scheduler_rr_arbiter #(
        .N_REQ (N_REQ),
        .NB_ID (NB_ID)
    ) u_arbiter (
        .eligible (eligible),
        .pointer  (ptr_q),
        .grant    (grant),
        .index    (grant_idx),
        .any      (grant_any)
    );

    assign sel_oper = i_req_data_bus[grant_idx * NB_OPER +: NB_OPER];

    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            if (grant_idx == NB_ID'(N_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + NB_ID'(1);
            end
        end
    end

    always_comb begin
        for (int k = 0; k < int'(N_REQ); k++) begin
            cnt_d[k] = cnt_q[k];
            unique case ({grant[k], rsp_hit[k]})
                2'b10:   cnt_d[k] = cnt_q[k] + NB_CNT'(1);
                2'b01:   cnt_d[k] = cnt_q[k] - NB_CNT'(1);
                default: cnt_d[k] = cnt_q[k];
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            ptr_q       <= '0;
            dp_valid_q  <= 1'b0;
            dp_data_q   <= '0;
            tag_valid_q <= '0;
            for (int k = 0; k < int'(N_REQ); k++) begin
                cnt_q[k] <= '0;
            end
            for (int s = 0; s < int'(NB_STAGE); s++) begin
                tag_id_q[s] <= '0;
            end
        end else begin
            ptr_q      <= ptr_d;
            dp_valid_q <= grant_any;
            if (grant_any) begin
                dp_data_q <= sel_oper;
            end
            for (int k = 0; k < int'(N_REQ); k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            tag_valid_q[0] <= grant_any;
            tag_id_q[0]    <= grant_idx;
            for (int s = 1; s < int'(NB_STAGE); s++) begin
                tag_valid_q[s] <= tag_valid_q[s-1];
                tag_id_q[s]    <= tag_id_q[s-1];
            end
        end
    end

    assign o_req_ready = grant;
    assign o_dp_valid  = dp_valid_q;
    assign o_dp_data   = dp_data_q;
    assign o_rsp_valid = rsp_hit;
    assign o_rsp_id    = out_valid ? out_id : '0;
    assign o_rsp_data  = i_dp_data;
    assign o_idle      = ~dp_valid_q & ~(|tag_valid_q);

endmodule

// File: tb/tb_gf_2ton_koa_merger_scheduler.sv
module tb_gf_2ton_koa_merger_scheduler;

    localparam int unsigned NR   = 4;
    localparam int unsigned NO   = 384;
    localparam int unsigned NRS  = 257;
    localparam int unsigned DPL  = 4;
    localparam int unsigned MAXO = 2;
    localparam int unsigned NI   = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*NO-1:0]  req_bus;
    logic [NO-1:0]     dp_data;
    logic              dp_valid;
    logic [NRS-1:0]    dp_result;
    logic [NR-1:0]     rsp_valid;
    logic [NRS-1:0]    rsp_data;
    logic [NI-1:0]     rsp_id;
    logic              idle;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gf_2ton_koa_merger_scheduler #(
        .N_REQ           (NR),
        .NB_OPER         (NO),
        .NB_RESULT       (NRS),
        .DP_LATENCY      (DPL),
        .MAX_OUTSTANDING (MAXO),
        .NB_ID           (NI)
    ) dut (
        .i_clock        (clk),
        .i_reset_n      (rst_n),
        .i_enable       (enable),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_data_bus (req_bus),
        .o_dp_data      (dp_data),
        .o_dp_valid     (dp_valid),
        .i_dp_data      (dp_result),
        .o_rsp_valid    (rsp_valid),
        .o_rsp_data     (rsp_data),
        .o_rsp_id       (rsp_id),
        .o_idle         (idle)
    );

    // Datapath model: XOR of the three operand slices, DPL cycles after issue.
    function automatic logic [NRS-1:0] merge(input logic [NO-1:0] op);
        return NRS'(op[127:0] ^ op[255:128] ^ op[383:256]);
    endfunction

    logic [NRS-1:0] dp_pipe [DPL];
    always @(posedge clk) begin
        dp_pipe[0] <= merge(dp_data);
        for (int i = 1; i < int'(DPL); i++) dp_pipe[i] <= dp_pipe[i-1];
    end
    assign dp_result = dp_pipe[DPL-1];

    task automatic chk(input string tag, input logic [NO-1:0] obs, input logic [NO-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Per-requester scoreboard of expected results, in issue order.
    logic [NRS-1:0] sb_mem [NR][8];
    int             sb_wr  [NR];
    int             sb_rd  [NR];

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(NR); k++) begin
                sb_wr[k] = 0;
                sb_rd[k] = 0;
            end
        end else begin
            chk("ready_legal", NO'(req_ready & ~req_valid), '0);
            if (rsp_valid != '0) begin
                chk("rsp_onehot", NO'(rsp_valid), NO'(1 << rsp_id));
                chk("sb_pending", NO'(sb_wr[rsp_id] > sb_rd[rsp_id]), NO'(1));
                chk("sb_data", NO'(rsp_data), NO'(sb_mem[rsp_id][sb_rd[rsp_id] % 8]));
                sb_rd[rsp_id] = sb_rd[rsp_id] + 1;
            end else begin
                chk("rsp_id_idle", NO'(rsp_id), '0);
            end
            for (int k = 0; k < int'(NR); k++) begin
                if (req_valid[k] && req_ready[k]) begin
                    sb_mem[k][sb_wr[k] % 8] = merge(NO'(req_bus >> (k * NO)));
                    sb_wr[k] = sb_wr[k] + 1;
                end
            end
        end
    end

    logic [NR-1:0] e_rdy  [9];
    logic [NR-1:0] e_rsp  [9];
    logic [NI-1:0] e_id   [9];
    logic [8:0]    e_idle;
    logic [10:0]   gpat;
    logic [10:0]   rpat;
    logic [3:0]    nib;

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b1;
        req_valid = 4'b1111;
        for (int k = 0; k < int'(NR); k++) begin
            nib = 4'(k + 1);
            req_bus[k*NO +: NO] = {96{nib}};
        end

        // Reset state, with requests pending
        cyc(); cyc(); #1;
        chk("rst_ready", NO'(req_ready), '0);
        chk("rst_rsp_valid", NO'(rsp_valid), '0);
        chk("rst_rsp_id", NO'(rsp_id), '0);
        chk("rst_idle", NO'(idle), NO'(1));
        chk("rst_dp_valid", NO'(dp_valid), '0);
        chk("rst_dp_data", dp_data, '0);
        rst_n     = 1'b1;
        req_valid = '0;
        cyc();

        // Single request from requester 2
        req_valid = 4'b0100; #1;
        chk("single_ready", NO'(req_ready), NO'(4'b0100));
        cyc();
        req_valid = '0; #1;
        chk("single_dp_valid", NO'(dp_valid), NO'(1));
        chk("single_dp_data", dp_data, {96{4'h3}});
        chk("single_busy", NO'(idle), '0);
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            chk("single_no_rsp", NO'(rsp_valid), '0);
        end
        cyc(); #1;
        chk("single_rsp_valid", NO'(rsp_valid), NO'(4'b0100));
        chk("single_rsp_id", NO'(rsp_id), NO'(2));
        chk("single_rsp_data", NO'(rsp_data), NO'({32{4'h3}}));
        cyc(); #1;
        chk("single_rsp_done", NO'(rsp_valid), '0);
        chk("single_idle", NO'(idle), NO'(1));

        // Fairness: pointer now 3, all requesters continuously valid
        req_valid = 4'b1111;
        for (int i = 0; i < 12; i++) begin
            #1;
            chk("rr_grant", NO'(req_ready), NO'(1 << ((3 + i) % 4)));
            if (i > 0) chk("rr_dp_valid", NO'(dp_valid), NO'(1));
            cyc();
        end
        req_valid = '0;
        for (int n = 0; n < 30 && !idle; n++) cyc();
        #1;
        chk("rr_drain_idle", NO'(idle), NO'(1));

        // Outstanding limit (2) with only requester 1 valid
        req_valid = 4'b0010;
        gpat = 11'b10001100011;
        rpat = 11'b10001100000;
        for (int i = 0; i < 11; i++) begin
            #1;
            chk("lim_grant", NO'(req_ready), gpat[i] ? NO'(4'b0010) : '0);
            chk("lim_rsp", NO'(rsp_valid), rpat[i] ? NO'(4'b0010) : '0);
            cyc();
        end
        req_valid = '0;
        for (int n = 0; n < 30 && !idle; n++) cyc();
        #1;
        chk("lim_drain_idle", NO'(idle), NO'(1));

        // Enable drops at cycle 3 with three operations in flight (pointer 2)
        e_rdy  = '{4'b0100, 4'b1000, 4'b0001, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0};
        e_rsp  = '{4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0100, 4'b1000, 4'b0001, 4'b0};
        e_id   = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd3, 2'd0, 2'd0};
        e_idle = 9'b100000001;
        req_valid = 4'b1111;
        for (int i = 0; i < 9; i++) begin
            if (i == 3) enable = 1'b0;
            #1;
            chk("en_ready", NO'(req_ready), NO'(e_rdy[i]));
            chk("en_rsp", NO'(rsp_valid), NO'(e_rsp[i]));
            chk("en_rsp_id", NO'(rsp_id), NO'(e_id[i]));
            chk("en_idle", NO'(idle), NO'(e_idle[i]));
            cyc();
        end
        req_valid = '0;
        enable    = 1'b1;

        // Reset one cycle after an issue (pointer 1: requester 3 wins)
        req_valid = 4'b1001; #1;
        chk("rst_mid_grant", NO'(req_ready), NO'(4'b1000));
        cyc();
        req_valid = '0; #1;
        chk("rst_mid_issue", NO'(dp_valid), NO'(1));
        cyc();
        rst_n     = 1'b0;
        req_valid = 4'b1001; #1;
        chk("rst_mid_ready", NO'(req_ready), '0);
        cyc();
        rst_n = 1'b1; #1;
        chk("rst_mid_regrant", NO'(req_ready), NO'(4'b0001));
        chk("rst_mid_idle", NO'(idle), NO'(1));
        cyc();
        req_valid = '0;
        for (int i = 4; i < 8; i++) begin
            #1;
            chk("rst_mid_killed", NO'(rsp_valid), '0);
            cyc();
        end
        #1;
        chk("rst_mid_rsp", NO'(rsp_valid), NO'(4'b0001));
        chk("rst_mid_rsp_id", NO'(rsp_id), '0);
        cyc();

        // Random traffic checked by the scoreboard monitor
        for (int c = 0; c < 600; c++) begin
            req_valid = NR'($urandom);
            enable    = ($urandom_range(0, 7) != 0);
            for (int w = 0; w < int'(NR * NO / 32); w++) req_bus[w*32 +: 32] = $urandom;
            cyc();
        end
        req_valid = '0;
        enable    = 1'b1;
        for (int n = 0; n < 30 && !idle; n++) cyc();
        cyc(); #1;
        chk("rand_drain_idle", NO'(idle), NO'(1));
        for (int k = 0; k < int'(NR); k++) begin
            chk("rand_sb_balance", NO'(sb_wr[k] - sb_rd[k]), '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
